// File: rtl/spi_reg_writer.sv
// ---------------------------------------------------------------------------
// spi_reg_writer
//   SPI mode-0 controller that sends one 16-bit register frame per request.
//   Frame order on the wire, MSB first: {rw, addr[6:0], data[7:0]}.
//   A request is accepted when req_valid is high while req_ready is high.
//   The sequence is: chip select low, setup delay, 16 SCLK pulses, hold delay,
//   then chip select high with a one-cycle done pulse, then an idle gap.
//
// Parameters
//   CLK_DIV   clk cycles per SCLK half-period (>= 1)
//   CS_SETUP  cycles ncs is low before the first SCLK rise (>= 1)
//   CS_HOLD   cycles of the hold phase before ncs rises (>= 1)
//   IDLE_GAP  minimum cycles ncs stays high between frames (>= 0)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  high only while idle
//   req_rw     frame bit 15 (1 = write)
//   req_addr   frame bits 14:8
//   req_data   frame bits 7:0
//   busy       high from the cycle after accept until idle again
//   done       one-cycle pulse when ncs returns high after a full frame
//   spi_sclk   SPI clock, idles low
//   spi_copi   controller data out
//   spi_ncs    chip select, active-low
//
// Optional feature (macro SPI_READBACK_EN)
//   spi_cipo   peripheral data in, sampled on SCLK rises of frame bits 7:0
//   rsp_data   captured byte, updated in the done cycle, holds until the next
// ---------------------------------------------------------------------------
module spi_reg_writer #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       spi_sclk,
  output logic       spi_copi,
  output logic       spi_ncs
`ifdef SPI_READBACK_EN
  ,
  input  logic       spi_cipo,
  output logic [7:0] rsp_data
`endif
);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("spi_reg_writer: CLK_DIV must be >= 1");
  end
  if (CS_SETUP < 1) begin : g_bad_cs_setup
    $error("spi_reg_writer: CS_SETUP must be >= 1");
  end
  if (CS_HOLD < 1) begin : g_bad_cs_hold
    $error("spi_reg_writer: CS_HOLD must be >= 1");
  end
  if (IDLE_GAP < 0) begin : g_bad_idle_gap
    $error("spi_reg_writer: IDLE_GAP must be >= 0");
  end

  localparam int HALF_W = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);

  // One shared counter times the SETUP, HOLD and GAP phases.
  localparam int WAIT_MAX0 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int WAIT_MAX1 = (WAIT_MAX0 > IDLE_GAP) ? WAIT_MAX0 : IDLE_GAP;
  localparam int WAIT_MAX  = (WAIT_MAX1 < 1) ? 1 : WAIT_MAX1;
  localparam int WAIT_W    = $clog2(WAIT_MAX + 1);

  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP - 1);
  localparam logic [WAIT_W-1:0] HOLD_LAST  = WAIT_W'(CS_HOLD - 1);
  localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [4:0]        bits_q, bits_d;
  logic [14:0]       shreg_q, shreg_d;
  logic              sclk_q, sclk_d;
  logic              copi_q, copi_d;
  logic              ncs_q, ncs_d;
  logic              done_q, done_d;
`ifdef SPI_READBACK_EN
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        rsp_q, rsp_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      half_q  <= '0;
      bits_q  <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
`ifdef SPI_READBACK_EN
      rx_q    <= '0;
      rsp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      half_q  <= half_d;
      bits_q  <= bits_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ncs_q   <= ncs_d;
      done_q  <= done_d;
`ifdef SPI_READBACK_EN
      rx_q    <= rx_d;
      rsp_q   <= rsp_d;
`endif
    end
  end

  // bit 15 goes straight into copi at accept, so the shift register only
  // holds the remaining 15 bits. bits_q counts SCLK rises issued so far.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    half_d  = half_q;
    bits_d  = bits_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    ncs_d   = ncs_q;
    done_d  = 1'b0;
`ifdef SPI_READBACK_EN
    rx_d    = rx_q;
    rsp_d   = rsp_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SETUP;
          shreg_d = {req_addr, req_data};
          copi_d  = req_rw;
          ncs_d   = 1'b0;
          wait_d  = '0;
        end
      end
      SETUP: begin
        if (wait_q == SETUP_LAST) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
          half_d  = '0;
          bits_d  = 5'd1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      SHIFT: begin
        // Each half-period lasts CLK_DIV cycles; the final low half after
        // the 16th fall completes before moving to HOLD.
        if (half_q == HALF_LAST) begin
          half_d = '0;
          if (sclk_q) begin
            sclk_d  = 1'b0;
            copi_d  = shreg_q[14];
            shreg_d = {shreg_q[13:0], 1'b0};
          end else if (bits_q == 5'd16) begin
            state_d = HOLD;
            wait_d  = '0;
          end else begin
            sclk_d = 1'b1;
            bits_d = bits_q + 5'd1;
`ifdef SPI_READBACK_EN
            // Rises 9..16 carry frame bits 7:0.
            if (bits_q >= 5'd8) begin
              rx_d = {rx_q[6:0], spi_cipo};
            end
`endif
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      HOLD: begin
        if (wait_q == HOLD_LAST) begin
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          copi_d  = 1'b0;
          wait_d  = '0;
          state_d = (IDLE_GAP == 0) ? IDLE : GAP;
`ifdef SPI_READBACK_EN
          rsp_d   = rx_q;
`endif
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      GAP: begin
        if (wait_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign spi_sclk  = sclk_q;
  assign spi_copi  = copi_q;
  assign spi_ncs   = ncs_q;
`ifdef SPI_READBACK_EN
  assign rsp_data  = rsp_q;
`endif

endmodule

// File: tb/tb_spi_reg_writer.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_writer
//   Drives two spi_reg_writer instances: dut0 with default timing and dut1
//   with the fastest legal timing and no idle gap. A peripheral model shifts
//   in copi on every SCLK rise; expected frames, ncs low time, latency, gap
//   and SCLK period are derived from the frame format and timing parameters.
// ---------------------------------------------------------------------------
module tb_spi_reg_writer;

  localparam int DIV0 = 2, SET0 = 2, HOLD0 = 2, GAP0 = 4;
  localparam int DIV1 = 1, SET1 = 1, HOLD1 = 1, GAP1 = 0;
  localparam int LOW0 = SET0 + 32 * DIV0 + HOLD0;
  localparam int LOW1 = SET1 + 32 * DIV1 + HOLD1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  logic       valid0 = 1'b0, ready0, rw0 = 1'b0, busy0, done0, sclk0, copi0, ncs0;
  logic [6:0] addr0 = '0;
  logic [7:0] data0 = '0;
  logic       valid1 = 1'b0, ready1, rw1 = 1'b0, busy1, done1, sclk1, copi1, ncs1;
  logic [6:0] addr1 = '0;
  logic [7:0] data1 = '0;
`ifdef SPI_READBACK_EN
  logic       cipo0 = 1'b0;
  logic       cipo1 = 1'b0;
  logic [7:0] rsp0, rsp1;
  logic [7:0] rspByte0 = 8'h00;
`endif

  spi_reg_writer #(.CLK_DIV(DIV0), .CS_SETUP(SET0), .CS_HOLD(HOLD0), .IDLE_GAP(GAP0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid0), .req_ready(ready0),
    .req_rw(rw0), .req_addr(addr0), .req_data(data0), .busy(busy0), .done(done0),
    .spi_sclk(sclk0), .spi_copi(copi0), .spi_ncs(ncs0)
`ifdef SPI_READBACK_EN
    , .spi_cipo(cipo0), .rsp_data(rsp0)
`endif
  );

  spi_reg_writer #(.CLK_DIV(DIV1), .CS_SETUP(SET1), .CS_HOLD(HOLD1), .IDLE_GAP(GAP1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_ready(ready1),
    .req_rw(rw1), .req_addr(addr1), .req_data(data1), .busy(busy1), .done(done1),
    .spi_sclk(sclk1), .spi_copi(copi1), .spi_ncs(ncs1)
`ifdef SPI_READBACK_EN
    , .spi_cipo(cipo1), .rsp_data(rsp1)
`endif
  );

  // Peripheral models: shift in copi on each SCLK rise, clear on ncs fall.
  logic [15:0] rx0 = '0, rx1 = '0;
  int rxBits0 = 0, rxBits1 = 0;
  logic copiAtRise0 = 1'b0, copiAtRise1 = 1'b0;

  always @(posedge sclk0) begin
    rx0 = {rx0[14:0], copi0};
    rxBits0++;
    copiAtRise0 = copi0;
  end
  always @(negedge ncs0) rxBits0 = 0;

  always @(posedge sclk1) begin
    rx1 = {rx1[14:0], copi1};
    rxBits1++;
    copiAtRise1 = copi1;
  end
  always @(negedge ncs1) rxBits1 = 0;

`ifdef SPI_READBACK_EN
  // Present the response byte MSB first, changing only after SCLK falls,
  // so that rises 9..16 see data bits 7..0.
  always @(negedge sclk0) begin
    int idx;
    idx = rxBits0 + 1;
    if (idx >= 9 && idx <= 16) cipo0 = rspByte0[16 - idx];
  end
`endif

  // Cycle-level monitors: ncs low run length, done pulses, SCLK rise period
  // within a frame, and copi changing while SCLK is high.
  int cyc0 = 0, lowRun0 = 0, lowLen0 = 0, doneCnt0 = 0, lastRise0 = -1;
  int minPer0 = 1000, maxPer0 = 0, stableViol0 = 0;
  logic sclkPrev0 = 1'b0;
  always @(negedge clk) begin
    cyc0++;
    if (ncs0 === 1'b0) lowRun0++;
    else if (lowRun0 != 0) begin
      lowLen0 = lowRun0;
      lowRun0 = 0;
    end
    if (done0 === 1'b1) doneCnt0++;
    if (ncs0 !== 1'b0) lastRise0 = -1;
    else if (sclk0 === 1'b1 && sclkPrev0 !== 1'b1) begin
      if (lastRise0 >= 0) begin
        if (cyc0 - lastRise0 < minPer0) minPer0 = cyc0 - lastRise0;
        if (cyc0 - lastRise0 > maxPer0) maxPer0 = cyc0 - lastRise0;
      end
      lastRise0 = cyc0;
    end
    if (sclk0 === 1'b1 && copi0 !== copiAtRise0) stableViol0++;
    sclkPrev0 = sclk0;
  end

  int cyc1 = 0, lowRun1 = 0, lowLen1 = 0, lastRise1 = -1;
  int minPer1 = 1000, maxPer1 = 0, stableViol1 = 0;
  logic sclkPrev1 = 1'b0;
  always @(negedge clk) begin
    cyc1++;
    if (ncs1 === 1'b0) lowRun1++;
    else if (lowRun1 != 0) begin
      lowLen1 = lowRun1;
      lowRun1 = 0;
    end
    if (ncs1 !== 1'b0) lastRise1 = -1;
    else if (sclk1 === 1'b1 && sclkPrev1 !== 1'b1) begin
      if (lastRise1 >= 0) begin
        if (cyc1 - lastRise1 < minPer1) minPer1 = cyc1 - lastRise1;
        if (cyc1 - lastRise1 > maxPer1) maxPer1 = cyc1 - lastRise1;
      end
      lastRise1 = cyc1;
    end
    if (sclk1 === 1'b1 && copi1 !== copiAtRise1) stableViol1++;
    sclkPrev1 = sclk1;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Issue one frame on dut0 and check start state, latency, frame contents,
  // ncs low time and the done pulse count.
  task automatic runFrame0(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                           input string name);
    logic [15:0] expFrame;
    int k;
    int doneBefore;
    expFrame   = {rw, addr, data};
    doneBefore = doneCnt0;
    @(negedge clk);
    valid0 = 1'b1; rw0 = rw; addr0 = addr; data0 = data;
    k = 0;
    while (ready0 !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    @(negedge clk);
    valid0 = 1'b0; rw0 = 1'($urandom); addr0 = 7'($urandom); data0 = 8'($urandom);
    checks++;
    if (ncs0 !== 1'b0 || busy0 !== 1'b1 || copi0 !== expFrame[15])
      $display("[TB] FAIL %s_start: ncs=%b busy=%b copi=%b, expected ncs=0 busy=1 copi=%b",
               name, ncs0, busy0, copi0, expFrame[15]);
    else passes++;
    k = 1;
    while (done0 !== 1'b1 && k < 500) begin @(negedge clk); k++; end
    checks++;
    if (k != LOW0 + 1)
      $display("[TB] FAIL %s_latency: accept to done %0d cycles, expected %0d", name, k, LOW0 + 1);
    else passes++;
    checks++;
    if (rxBits0 != 16 || rx0 !== expFrame)
      $display("[TB] FAIL %s_frame: got %h (%0d bits), expected %h (16 bits)",
               name, rx0, rxBits0, expFrame);
    else passes++;
`ifdef SPI_READBACK_EN
    checks++;
    if (rsp0 !== rspByte0)
      $display("[TB] FAIL %s_rsp: rsp_data=%h, expected %h", name, rsp0, rspByte0);
    else passes++;
`endif
    @(negedge clk);
    checks++;
    if (lowLen0 != LOW0 || doneCnt0 != doneBefore + 1)
      $display("[TB] FAIL %s_ncs_done: ncs low %0d, done pulses %0d, expected %0d and %0d",
               name, lowLen0, doneCnt0 - doneBefore, LOW0, 1);
    else passes++;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ncs0 !== 1'b1) $display("[TB] FAIL reset_ncs: got %b, expected 1", ncs0); else passes++;
    checks++;
    if (sclk0 !== 1'b0) $display("[TB] FAIL reset_sclk: got %b, expected 0", sclk0); else passes++;
    checks++;
    if (copi0 !== 1'b0) $display("[TB] FAIL reset_copi: got %b, expected 0", copi0); else passes++;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0)
      $display("[TB] FAIL reset_busy_done: busy=%b done=%b, expected 0 0", busy0, done0);
    else passes++;
    checks++;
    if (ready0 !== 1'b1) $display("[TB] FAIL reset_ready: got %b, expected 1", ready0); else passes++;
    checks++;
    if ({ncs1, sclk1, copi1, busy1, done1, ready1} !== 6'b100001)
      $display("[TB] FAIL reset_dut1: ncs/sclk/copi/busy/done/ready=%b, expected 100001",
               {ncs1, sclk1, copi1, busy1, done1, ready1});
    else passes++;
`ifdef SPI_READBACK_EN
    checks++;
    if (rsp0 !== 8'h00) $display("[TB] FAIL reset_rsp: got %h, expected 00", rsp0); else passes++;
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ncs0 !== 1'b1 || ready0 !== 1'b1)
      $display("[TB] FAIL post_reset_idle: ncs=%b ready=%b, expected 1 1", ncs0, ready0);
    else passes++;
  endtask

  task automatic test_basic_write;
    runFrame0(1'b1, 7'h00, 8'hF0, "write_80F0");
  endtask

  task automatic test_random_frames;
    for (int n = 0; n < 4; n++) begin
`ifdef SPI_READBACK_EN
      rspByte0 = 8'($urandom);
`endif
      runFrame0(1'($urandom), 7'($urandom), 8'($urandom), "random");
    end
    checks++;
    if (minPer0 != 2 * DIV0 || maxPer0 != 2 * DIV0)
      $display("[TB] FAIL sclk_period0: min %0d max %0d, expected %0d", minPer0, maxPer0, 2 * DIV0);
    else passes++;
    checks++;
    if (stableViol0 != 0)
      $display("[TB] FAIL copi_stable0: %0d changes while sclk high, expected 0", stableViol0);
    else passes++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] f1, f2;
    int k, g, readyLeak;
    f1 = 16'($urandom);
    f2 = 16'($urandom);
    @(negedge clk);
    valid0 = 1'b1; {rw0, addr0, data0} = f1;
    k = 0;
    while (ready0 !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    @(negedge clk);
    {rw0, addr0, data0} = f2;
    k = 1; readyLeak = 0;
    while (done0 !== 1'b1 && k < 500) begin
      if (ready0 !== 1'b0) readyLeak++;
      @(negedge clk); k++;
    end
    if (ready0 !== 1'b0) readyLeak++;
    checks++;
    if (readyLeak != 0)
      $display("[TB] FAIL b2b_ready_low: ready high in %0d frame cycles, expected 0", readyLeak);
    else passes++;
    checks++;
    if (rx0 !== f1) $display("[TB] FAIL b2b_frame1: got %h, expected %h", rx0, f1); else passes++;
    g = 0;
    while (ready0 !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    checks++;
    if (g != GAP0) $display("[TB] FAIL b2b_gap: %0d cycles done to accept, expected %0d", g, GAP0);
    else passes++;
    @(negedge clk);
    valid0 = 1'b0;
    checks++;
    if (ncs0 !== 1'b0 || copi0 !== f2[15])
      $display("[TB] FAIL b2b_start2: ncs=%b copi=%b, expected 0 %b", ncs0, copi0, f2[15]);
    else passes++;
    k = 1;
    while (done0 !== 1'b1 && k < 500) begin @(negedge clk); k++; end
    checks++;
    if (rx0 !== f2 || k != LOW0 + 1)
      $display("[TB] FAIL b2b_frame2: got %h after %0d cycles, expected %h after %0d",
               rx0, k, f2, LOW0 + 1);
    else passes++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mid_reset;
    int k, doneBefore;
    @(negedge clk);
    valid0 = 1'b1; rw0 = 1'b1; addr0 = 7'($urandom); data0 = 8'($urandom);
    k = 0;
    while (ready0 !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    @(negedge clk);
    valid0 = 1'b0;
    k = 0;
    while (rxBits0 < 5 && k < 200) begin @(negedge clk); k++; end
    doneBefore = doneCnt0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ncs0, sclk0, copi0, busy0, ready0} !== 5'b10001)
      $display("[TB] FAIL midreset_async: ncs/sclk/copi/busy/ready=%b, expected 10001",
               {ncs0, sclk0, copi0, busy0, ready0});
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (doneCnt0 != doneBefore || ncs0 !== 1'b1)
      $display("[TB] FAIL midreset_no_done: %0d done pulses ncs=%b, expected 0 pulses ncs=1",
               doneCnt0 - doneBefore, ncs0);
    else passes++;
    runFrame0(1'b1, 7'h02, 8'hFF, "after_reset_82FF");
  endtask

  task automatic test_fast_config;
    logic [15:0] f;
    int k;
    logic expRdy;
    expRdy = (GAP1 == 0);
    for (int n = 0; n < 3; n++) begin
      f = 16'($urandom);
      @(negedge clk);
      valid1 = 1'b1; {rw1, addr1, data1} = f;
      k = 0;
      while (ready1 !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      @(negedge clk);
      valid1 = 1'b0;
      k = 1;
      while (done1 !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      checks++;
      if (k != LOW1 + 1)
        $display("[TB] FAIL fast_latency: %0d cycles, expected %0d", k, LOW1 + 1);
      else passes++;
      checks++;
      if (rx1 !== f || rxBits1 != 16)
        $display("[TB] FAIL fast_frame: got %h (%0d bits), expected %h", rx1, rxBits1, f);
      else passes++;
      checks++;
      if (ready1 !== expRdy)
        $display("[TB] FAIL fast_ready_at_done: got %b, expected %b", ready1, expRdy);
      else passes++;
      @(negedge clk);
      checks++;
      if (lowLen1 != LOW1)
        $display("[TB] FAIL fast_ncs_low: %0d cycles, expected %0d", lowLen1, LOW1);
      else passes++;
    end
    checks++;
    if (minPer1 != 2 * DIV1 || maxPer1 != 2 * DIV1 || stableViol1 != 0)
      $display("[TB] FAIL fast_sclk: period min %0d max %0d copi changes %0d, expected %0d %0d 0",
               minPer1, maxPer1, stableViol1, 2 * DIV1, 2 * DIV1);
    else passes++;
  endtask

`ifdef SPI_READBACK_EN
  task automatic test_readback;
    rspByte0 = 8'hA5;
    runFrame0(1'b0, 7'($urandom), 8'($urandom), "readback_A5");
    rspByte0 = 8'h3C;
    repeat (5) @(negedge clk);
    checks++;
    if (rsp0 !== 8'hA5) $display("[TB] FAIL readback_hold: got %h, expected a5", rsp0); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_write();
    test_random_frames();
    test_back_to_back();
    test_mid_reset();
    test_fast_config();
`ifdef SPI_READBACK_EN
    test_readback();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
